// File: rtl/fifo_stream_rd_if.sv
// FIFO read-side and valid/ready stream signals for fifo_stream_rd.
// The master modport is the drain stage; the slave modport is the FIFO plus downstream sink.
interface fifo_stream_rd_if #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 12
);
   logic [ADDR_WIDTH:0]   fifo_data_count;
   logic                  fifo_rd_en;
   logic [DATA_WIDTH-1:0] fifo_dout;
   logic                  m_valid;
   logic                  m_ready;
   logic [DATA_WIDTH-1:0] m_data;
   logic                  m_last;

   modport master (
      input  fifo_data_count, fifo_dout, m_ready,
      output fifo_rd_en, m_valid, m_data, m_last
   );

   modport slave (
      output fifo_data_count, fifo_dout, m_ready,
      input  fifo_rd_en, m_valid, m_data, m_last
   );
endinterface

// File: rtl/fifo_stream_rd.sv
// Drains a 1-cycle-latency synchronous FIFO into a framed valid/ready stream.
// A 3-entry skid buffer plus an in-flight credit keeps m_ready off the fifo_rd_en path.
module fifo_stream_rd #(
   parameter int DATA_WIDTH = 128,
   parameter int ADDR_WIDTH = 12,
   parameter int PKT_LEN    = 16
) (
   input  logic                  clk,
   input  logic                  srst,
   fifo_stream_rd_if.master      bus,
   output logic [1:0]            buf_count,
   output logic [31:0]           beat_total
);

   localparam logic [15:0] LAST_IDX = 16'(PKT_LEN - 1);

   logic [DATA_WIDTH-1:0] mem [3];
   logic [1:0]            wr_ptr;
   logic [1:0]            rd_ptr;
   logic                  inflight;
   logic [15:0]           beat_idx;
   logic                  credit_ok;
   logic                  pop;

   // Credit counts the word already requested but not yet captured, so the buffer never overflows.
   always_comb begin
      credit_ok      = ({1'b0, buf_count} + {2'b00, inflight}) < 3'd3;
      bus.fifo_rd_en = srst && (bus.fifo_data_count != '0) && credit_ok;
      bus.m_valid    = (buf_count != 2'd0);
      bus.m_data     = mem[rd_ptr];
      bus.m_last     = bus.m_valid && (beat_idx == LAST_IDX);
      pop            = bus.m_valid && bus.m_ready;
   end

   always_ff @(posedge clk or negedge srst) begin
      if (!srst) begin
         for (int unsigned i = 0; i < 3; i++) mem[i] <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         inflight   <= 1'b0;
         buf_count  <= '0;
         beat_idx   <= '0;
         beat_total <= '0;
      end else begin
         inflight <= bus.fifo_rd_en;

         if (inflight) begin
            mem[wr_ptr] <= bus.fifo_dout;
            wr_ptr      <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
         end

         if (pop) begin
            rd_ptr     <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            beat_total <= beat_total + 32'd1;
            beat_idx   <= (beat_idx == LAST_IDX) ? 16'd0 : beat_idx + 16'd1;
         end

         case ({inflight, pop})
            2'b10:   buf_count <= buf_count + 2'd1;
            2'b01:   buf_count <= buf_count - 2'd1;
            default: buf_count <= buf_count;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_stream_rd.sv
// Bench for fifo_stream_rd: behavioural FIFO model, per-cycle stream monitor and scoreboard,
// a vector table for the single-word case and directed sequences for the multi-cycle cases.
module tb_fifo_stream_rd;

   localparam int DW  = 128;
   localparam int AW  = 12;
   localparam int PKT = 16;

   logic        clk;
   logic        srst;
   logic [1:0]  buf_count;
   logic [31:0] beat_total;

   logic          wr_en;
   logic [DW-1:0] wr_data;
   logic          fifo_clr;
   logic [DW-1:0] q[$];
   logic [DW-1:0] sb[$];

   int total;
   int bad;
   int cyc_n;
   int mdl_buf;
   logic mdl_infl;
   int mdl_idx;
   int acc_cnt;
   int last_cnt;
   int first_last;
   int first_acc_cyc;
   int last_acc_cyc;
   logic prev_stall;
   logic [DW-1:0] prev_data;
   logic smp_rd;

   fifo_stream_rd_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   fifo_stream_rd #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LEN(PKT)) dut (
      .clk        (clk),
      .srst       (srst),
      .bus        (bus),
      .buf_count  (buf_count),
      .beat_total (beat_total)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Synchronous FIFO: registered occupancy, read data one cycle after rd_en.
   always @(posedge clk) begin
      if (fifo_clr) begin
         q.delete();
         bus.fifo_dout       <= '0;
         bus.fifo_data_count <= '0;
      end else begin
         if (bus.fifo_rd_en && q.size() != 0) bus.fifo_dout <= q.pop_front();
         if (wr_en) q.push_back(wr_data);
         bus.fifo_data_count <= (AW+1)'(q.size());
      end
   end

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic mon();
      int nb;
      logic acc;
      cyc_n++;
      smp_rd = bus.fifo_rd_en;
      if (!srst) begin
         mdl_buf = 0; mdl_infl = 1'b0; mdl_idx = 0; acc_cnt = 0; last_cnt = 0;
         first_last = 0; prev_stall = 1'b0;
      end else begin
         chk("buf_count", 128'(buf_count), 128'(mdl_buf));
         chk("m_valid", 128'(bus.m_valid), 128'(mdl_buf != 0));
         if (bus.fifo_data_count == '0) chk("rd_en_when_empty", 128'(bus.fifo_rd_en), 128'(0));
         if (prev_stall) begin
            chk("hold_valid", 128'(bus.m_valid), 128'(1));
            chk("hold_data", bus.m_data, prev_data);
         end
         chk("m_last", 128'(bus.m_last), 128'(bus.m_valid && mdl_idx == PKT - 1));
         acc = bus.m_valid && bus.m_ready;
         if (acc) begin
            chk("sb_nonempty", 128'(sb.size() != 0), 128'(1));
            if (sb.size() != 0) chk("m_data", bus.m_data, sb.pop_front());
            acc_cnt++;
            if (acc_cnt == 1) first_acc_cyc = cyc_n;
            last_acc_cyc = cyc_n;
            if (bus.m_last) begin
               last_cnt++;
               if (first_last == 0) first_last = acc_cnt;
            end
            mdl_idx = (mdl_idx == PKT - 1) ? 0 : mdl_idx + 1;
         end
         nb = mdl_buf + int'(mdl_infl) - int'(acc);
         chk("buf_overflow", 128'(nb > 3), 128'(0));
         mdl_buf    = nb;
         mdl_infl   = bus.fifo_rd_en;
         prev_stall = bus.m_valid && !bus.m_ready;
         prev_data  = bus.m_data;
      end
   endtask

   task automatic step();
      @(negedge clk);
      mon();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [DW-1:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      sb.push_back(d);
      step();
      wr_en = 1'b0;
   endtask

   task automatic wait_acc(input int n, input int budget, input string nm);
      for (int i = 0; i < budget && acc_cnt < n; i++) step();
      chk(nm, 128'(acc_cnt), 128'(n));
   endtask

   task automatic do_reset();
      srst     = 1'b0;
      wr_en    = 1'b0;
      bus.m_ready = 1'b0;
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
      sb.delete();
      step();
      srst = 1'b1;
      step();
   endtask

   typedef struct {
      logic          wr_en;
      logic [DW-1:0] wr_data;
      logic          m_ready;
      logic          exp_rd_en;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic [1:0]    exp_buf;
      logic          exp_last;
   } vec_t;

   vec_t tbl[6];
   int   pulses;
   int   written;

   initial begin
      tbl[0] = '{1'b1, 128'hA5, 1'b1, 1'b0, 1'b0, 128'h0,  2'd0, 1'b0};
      tbl[1] = '{1'b0, 128'h0,  1'b1, 1'b1, 1'b0, 128'h0,  2'd0, 1'b0};
      tbl[2] = '{1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 128'h0,  2'd0, 1'b0};
      tbl[3] = '{1'b0, 128'h0,  1'b1, 1'b0, 1'b1, 128'hA5, 2'd1, 1'b0};
      tbl[4] = '{1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 128'h0,  2'd0, 1'b0};
      tbl[5] = '{1'b0, 128'h0,  1'b1, 1'b0, 1'b0, 128'h0,  2'd0, 1'b0};

      total = 0; bad = 0; cyc_n = 0;
      mdl_buf = 0; mdl_infl = 1'b0; mdl_idx = 0; acc_cnt = 0; last_cnt = 0;
      first_last = 0; first_acc_cyc = 0; last_acc_cyc = 0; prev_stall = 1'b0;
      prev_data = '0; smp_rd = 1'b0;
      srst = 1'b0; wr_en = 1'b0; wr_data = '0; fifo_clr = 1'b1; bus.m_ready = 1'b0;
      step();
      fifo_clr = 1'b0;

      // 1: reset holds everything off even with words in the FIFO
      for (int i = 0; i < 5; i++) begin
         wr_en = 1'b1; wr_data = 128'(i + 1); step();
      end
      wr_en = 1'b0;
      step();
      for (int i = 0; i < 3; i++) begin
         chk("t1_count", 128'(bus.fifo_data_count), 128'(5));
         chk("t1_rd_en", 128'(bus.fifo_rd_en), 128'(0));
         chk("t1_valid", 128'(bus.m_valid), 128'(0));
         chk("t1_last", 128'(bus.m_last), 128'(0));
         chk("t1_data", bus.m_data, 128'(0));
         chk("t1_buf", 128'(buf_count), 128'(0));
         chk("t1_total", 128'(beat_total), 128'(0));
         step();
      end
      do_reset();

      // 2: single word, vector table
      for (int r = 0; r < 6; r++) begin
         wr_en = tbl[r].wr_en;
         wr_data = tbl[r].wr_data;
         bus.m_ready = tbl[r].m_ready;
         if (tbl[r].wr_en) sb.push_back(tbl[r].wr_data);
         @(negedge clk);
         mon();
         chk($sformatf("t2_rd_en[%0d]", r), 128'(bus.fifo_rd_en), 128'(tbl[r].exp_rd_en));
         chk($sformatf("t2_valid[%0d]", r), 128'(bus.m_valid), 128'(tbl[r].exp_valid));
         chk($sformatf("t2_buf[%0d]", r), 128'(buf_count), 128'(tbl[r].exp_buf));
         chk($sformatf("t2_last[%0d]", r), 128'(bus.m_last), 128'(tbl[r].exp_last));
         if (tbl[r].exp_valid) chk($sformatf("t2_data[%0d]", r), bus.m_data, tbl[r].exp_data);
         @(posedge clk);
         #1;
      end
      wr_en = 1'b0;
      chk("t2_total", 128'(beat_total), 128'(1));

      // 3: 64-word stream at full rate
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 64; i++) push_word(128'(i));
      wait_acc(64, 200, "t3_accepted");
      chk("t3_contiguous", 128'(last_acc_cyc - first_acc_cyc), 128'(63));
      chk("t3_last_cnt", 128'(last_cnt), 128'(4));
      chk("t3_first_last", 128'(first_last), 128'(16));
      chk("t3_beat_total", 128'(beat_total), 128'(64));

      // 4: backpressure fills the skid buffer and stops reads
      do_reset();
      pulses = 0;
      for (int i = 0; i < 10; i++) begin
         push_word(128'(100 + i));
         if (smp_rd) pulses++;
      end
      for (int i = 0; i < 10; i++) begin
         step();
         if (smp_rd) pulses++;
      end
      chk("t4_pulses", 128'(pulses), 128'(3));
      chk("t4_buf", 128'(buf_count), 128'(3));
      chk("t4_count", 128'(bus.fifo_data_count), 128'(7));
      chk("t4_head", bus.m_data, 128'(100));
      bus.m_ready = 1'b1;
      wait_acc(10, 100, "t4_accepted");
      step();
      step();
      chk("t4_sb_empty", 128'(sb.size()), 128'(0));
      chk("t4_valid_idle", 128'(bus.m_valid), 128'(0));

      // 5: random writes and random backpressure
      do_reset();
      written = 0;
      for (int i = 0; i < 30000 && acc_cnt < 1000; i++) begin
         wr_en = (written < 1000) && ($urandom_range(0, 1) == 1);
         if (wr_en) begin
            wr_data = {$urandom, $urandom, $urandom, $urandom};
            sb.push_back(wr_data);
            written++;
         end
         bus.m_ready = ($urandom_range(0, 1) == 1);
         step();
      end
      wr_en = 1'b0;
      chk("t5_accepted", 128'(acc_cnt), 128'(1000));
      chk("t5_sb_empty", 128'(sb.size()), 128'(0));
      chk("t5_last_cnt", 128'(last_cnt), 128'(62));
      chk("t5_beat_total", 128'(beat_total), 128'(1000));

      // 6: asynchronous reset with two words buffered and beat_idx at 5
      do_reset();
      bus.m_ready = 1'b1;
      for (int i = 0; i < 5; i++) push_word(128'(200 + i));
      wait_acc(5, 50, "t6_pre_accepted");
      bus.m_ready = 1'b0;
      push_word(128'(300));
      push_word(128'(301));
      for (int i = 0; i < 20 && buf_count != 2'd2; i++) step();
      chk("t6_pre_buf", 128'(buf_count), 128'(2));
      @(negedge clk);
      #2;
      srst = 1'b0;
      #1;
      chk("t6_valid", 128'(bus.m_valid), 128'(0));
      chk("t6_buf", 128'(buf_count), 128'(0));
      chk("t6_data", bus.m_data, 128'(0));
      chk("t6_last", 128'(bus.m_last), 128'(0));
      chk("t6_total", 128'(beat_total), 128'(0));
      chk("t6_rd_en", 128'(bus.fifo_rd_en), 128'(0));
      @(posedge clk);
      #1;
      fifo_clr = 1'b1;
      step();
      fifo_clr = 1'b0;
      sb.delete();
      step();
      srst = 1'b1;
      bus.m_ready = 1'b1;
      for (int i = 0; i < 20; i++) push_word(128'(400 + i));
      wait_acc(20, 100, "t6_post_accepted");
      chk("t6_first_last", 128'(first_last), 128'(16));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fifo_stream_rd.md
Name: fifo_stream_rd

Overview:
- Read-side drain stage placed directly downstream of the team's synchronous FIFO (1-cycle registered RAM read latency, data_count occupancy output).
- Issues FIFO read enables, absorbs the read latency with a 3-entry skid buffer, and presents a valid/ready stream with packet framing (m_last every PKT_LEN beats).
- Supports full throughput with no combinational path from m_ready to fifo_rd_en.

Parameters:
DATA_WIDTH, 128, width of FIFO data and stream data
ADDR_WIDTH, 12, FIFO address width; fifo_data_count is ADDR_WIDTH+1 bits
PKT_LEN, 16, beats per packet for m_last generation; legal range 1..65535

Ports:
clk  in  1  clock
srst  in  1  reset, asynchronous, active-low
fifo_data_count  in  ADDR_WIDTH+1  registered FIFO occupancy
fifo_rd_en  out  1  FIFO read enable
fifo_dout  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rd_en
m_valid  out  1  stream data valid
m_ready  in  1  downstream accept
m_data  out  DATA_WIDTH  stream data, head of skid buffer
m_last  out  1  last beat of packet
buf_count  out  2  skid buffer occupancy, 0..3
beat_total  out  32  total beats accepted downstream, wraps modulo 2^32

Behaviour:
- Reset:
  - All registers clear: buffer pointers, buf_count=0, inflight=0, beat_idx=0, beat_total=0.
  - m_valid=0, m_last=0, m_data=0.
  - fifo_rd_en is forced 0 while srst is low, regardless of fifo_data_count.
- Read issue:
  - fifo_rd_en = srst && (fifo_data_count != 0) && (buf_count + inflight < 3).
  - inflight is a register equal to the previous cycle's fifo_rd_en.
  - FIFO empty is not used; it depends combinationally on rd_en and would form a loop. fifo_data_count is registered and already reflects earlier reads.
- Capture: when inflight=1, fifo_dout is written into the buffer at the write pointer. The write pointer wraps 2->0.
- Pop:
  - Occurs when m_valid && m_ready; the read pointer advances and wraps 2->0.
  - m_valid = (buf_count != 0).
  - m_data = entry at the read pointer.
- buf_count:
  - Next value = buf_count + capture - pop.
  - Simultaneous capture and pop leaves it unchanged.
  - Never exceeds 3; the credit rule guarantees this. The bench asserts overflow never occurs.
- Latency and throughput:
  - Word present with an empty buffer: fifo_rd_en in cycle t, captured end of t+1, m_valid in t+2.
  - Sustained throughput is 1 beat/cycle with m_ready=1.
- Framing:
  - beat_idx counts popped beats, 0..PKT_LEN-1, and wraps to 0 after the pop at PKT_LEN-1.
  - m_last = m_valid && (beat_idx == PKT_LEN-1).
  - PKT_LEN=1: m_last = m_valid on every beat.
  - beat_idx only changes on pop, so m_last is stable under backpressure.
- beat_total increments by 1 per pop.
- Stream rule: once m_valid=1, m_valid and m_data hold until accepted.
- Reset mid-operation: buffered and in-flight words are discarded, and framing restarts at beat_idx=0.

Test Plan:
1. Reset: srst=0, fifo_data_count=5 -> fifo_rd_en=0, m_valid=0, buf_count=0, beat_total=0 throughout reset.
2. Single word: FIFO write 0xA5, m_ready=1.
   - Exactly one fifo_rd_en pulse; m_valid high 2 cycles later with m_data=0xA5 for one cycle.
   - No further fifo_rd_en once fifo_data_count=0.
3. Stream: 64 incrementing words, m_ready=1.
   - 64 consecutive m_valid cycles after 2-cycle latency, data 0..63 in order.
   - m_last on beats 15/31/47/63; beat_total=64.
4. Backpressure: 10 words, m_ready=0.
   - Exactly 3 fifo_rd_en pulses; buf_count=3, fifo_data_count=7, m_data=word0 held.
   - After m_ready=1, all 10 words arrive in order with no loss or duplication.
5. Random: 1000 words, random writes, m_ready 50% random.
   - Scoreboard match and buf_count<=3.
   - fifo_rd_en never asserted with fifo_data_count=0; m_last every 16th accepted beat.
6. Mid-stream reset with buf_count=2, beat_idx=5.
   - Outputs clear immediately (asynchronous).
   - After release, first m_last falls on the 16th accepted beat.
